fifo_line_reader: RTL

Read-side scheduler for the video scaler's pixel FIFO. On a per-line request from the downstream scaler core, it issues exactly one line's worth of FIFO reads, stalls cleanly on FIFO empty, and retimes the returned data into a framed pixel stream with start-of-frame and end-of-line markers. It tracks line count per frame and flags underrun stalls that exceed a timeout.

---
 rtl/fifo_line_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fifo_line_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_line_reader
//  Purpose  : Issues one line of pixel-FIFO reads per downstream request and
//             frames the returned data with SOF/EOL markers.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_line_reader #(
    parameter int DW   = 24,
    parameter int WW   = 12,
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WW-1:0]   cfg_width,
    input  logic [WW-1:0]   cfg_height,
    input  logic [TO_W-1:0] cfg_timeout,
    input  logic            line_req,
    output logic            line_busy,
    input  logic            fifo_empty,
    output logic            fifo_re,
    input  logic [DW-1:0]   fifo_dout,
    input  logic            fifo_dout_valid,
    output logic [DW-1:0]   pix_data,
    output logic            pix_valid,
    output logic            pix_sof,
    output logic            pix_eol,
    output logic            frame_done,
    output logic            err_underrun
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [WW:0] c_ONE = {{WW{1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [WW:0]     r_width;
    logic [WW:0]     r_height;
    logic [WW:0]     r_issued;
    logic [WW:0]     r_recv;
    logic [WW:0]     r_line;
    logic [TO_W-1:0] r_stall;
    logic            r_err;
    logic            r_re_d;
    logic [DW-1:0]   r_pix_data;
    logic            r_pix_valid;
    logic            r_pix_sof;
    logic            r_pix_eol;

    logic            w_accept_line;
    logic            w_re;
    logic            w_last_issue;
    logic            w_rx;
    logic            w_eol_beat;
    logic [WW:0]     w_line_inc;
    logic [WW:0]     w_cfg_w;
    logic [WW:0]     w_cfg_h;
    logic [TO_W-1:0] w_stall_inc;

    assign w_accept_line = (r_state == c_IDLE) && line_req;
    assign w_re          = (r_state == c_READ) && !fifo_empty && (r_issued < r_width);
    assign w_last_issue  = w_re && ((r_issued + c_ONE) == r_width);
    // Returned data only counts if a read was actually issued the cycle before.
    assign w_rx          = fifo_dout_valid && r_re_d;
    assign w_eol_beat    = r_pix_valid && r_pix_eol;
    assign w_line_inc    = r_line + c_ONE;
    assign w_cfg_w       = (cfg_width  == '0) ? c_ONE : {1'b0, cfg_width};
    assign w_cfg_h       = (cfg_height == '0) ? c_ONE : {1'b0, cfg_height};
    assign w_stall_inc   = (r_stall == '1) ? r_stall : r_stall + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (line_req)     w_state_nxt = c_READ;
            c_READ:  if (w_last_issue) w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_eol_beat)   w_state_nxt = (w_line_inc == r_height) ? c_DONE : c_IDLE;
            c_DONE:                    w_state_nxt = c_IDLE;
            default:                   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_issued    <= '0;
            r_recv      <= '0;
            r_line      <= '0;
            r_stall     <= '0;
            r_err       <= 1'b0;
            r_re_d      <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_sof   <= 1'b0;
            r_pix_eol   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_re_d  <= w_re;

            if (w_re) begin
                r_issued <= r_issued + c_ONE;
                r_stall  <= '0;
            end else if ((r_state == c_READ) && fifo_empty) begin
                r_stall <= w_stall_inc;
                if ((cfg_timeout != '0) && (w_stall_inc >= cfg_timeout))
                    r_err <= 1'b1;
            end

            r_pix_valid <= w_rx;
            r_pix_sof   <= w_rx && (r_recv == '0) && (r_line == '0);
            r_pix_eol   <= w_rx && ((r_recv + c_ONE) == r_width);
            if (w_rx) begin
                r_pix_data <= fifo_dout;
                r_recv     <= r_recv + c_ONE;
            end

            if ((r_state == c_DRAIN) && w_eol_beat)
                r_line <= w_line_inc;
            else if (r_state == c_DONE)
                r_line <= '0;

            // Geometry is frozen for the whole frame once line 0 starts.
            if (w_accept_line) begin
                r_issued <= '0;
                r_recv   <= '0;
                r_stall  <= '0;
                if (r_line == '0) begin
                    r_width  <= w_cfg_w;
                    r_height <= w_cfg_h;
                end
            end
        end
    end

    assign line_busy    = (r_state == c_READ) || (r_state == c_DRAIN);
    assign fifo_re      = w_re;
    assign frame_done   = (r_state == c_DONE);
    assign err_underrun = r_err;
    assign pix_data     = r_pix_data;
    assign pix_valid    = r_pix_valid;
    assign pix_sof      = r_pix_sof;
    assign pix_eol      = r_pix_eol;

endmodule
`default_nettype wire
